cache_line_mem: RTL

CACHE_LINE_MEM -- requirements
Module: cache_line_mem

---
 rtl/cache_line_mem.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cache_line_mem.sv
// cache_line_mem: line-granular backing store for a cache.
// Refills stream 8 x 64-bit beats after a fixed LAT-cycle access latency.
// Writebacks accept 8 beats in line order and acknowledge with wr_done_o.
// Optional build macro CACHE_LINE_MEM_CWF_EN selects critical-word-first refill.
// When it is undefined, refills always start at beat 0.
module cache_line_mem #(
    parameter int ADDR_W = 20,
    parameter int LAT    = 4
) (
    input  logic              clk_sys_i,
    input  logic              rst_sys_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              wdata_valid_i,
    input  logic [63:0]       wdata_i,
    output logic              wdata_ready_o,
    output logic              rdata_valid_o,
    output logic [63:0]       rdata_o,
    output logic              rdata_last_o,
    input  logic              rdata_ready_i,
    output logic              wr_done_o
);

    localparam int WORD_W = ADDR_W - 3;
    localparam int LINE_W = ADDR_W - 6;
    localparam int DEPTH  = 1 << WORD_W;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD_BURST,
        S_WR_BURST,
        S_WR_ACK
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [LINE_W-1:0] r_line;
    logic [2:0]        r_beat;
    logic [3:0]        r_cnt;
    logic [63:0]       r_mem [0:DEPTH-1];
    logic [63:0]       r_rdata;

    logic              w_req_acc;
    logic              w_rd_hs;
    logic              w_wr_hs;
    logic              w_lat_done;
    logic              w_rd_last;
    logic              w_wr_last;
    logic [2:0]        w_start_beat;
    logic [2:0]        w_beat_inc;
    logic [WORD_W-1:0] w_rd_addr;
    logic [WORD_W-1:0] w_wr_addr;
    logic              w_unused_addr;

    assign w_req_acc  = req_valid_i && (r_state == S_IDLE);
    assign w_rd_hs    = (r_state == S_RD_BURST) && rdata_ready_i;
    assign w_wr_hs    = (r_state == S_WR_BURST) && wdata_valid_i;
    assign w_lat_done = (r_cnt == LAT_M1);
    // r_cnt counts emitted beats while in RD_BURST, so 7 marks the final one.
    assign w_rd_last  = (r_cnt == 4'd7);
    assign w_wr_last  = (r_beat == 3'd7);
    // 3-bit add: the beat index wraps inside the line and never carries into r_line.
    assign w_beat_inc = r_beat + 3'd1;

`ifdef CACHE_LINE_MEM_CWF_EN
    assign w_start_beat  = req_addr_i[5:3];
    assign w_unused_addr = ^req_addr_i[2:0];
`else
    assign w_start_beat  = 3'd0;
    assign w_unused_addr = ^req_addr_i[5:0];
`endif

    // Look one beat ahead on a handshake so r_rdata already holds the next word.
    // WAIT pre-fetches the first beat, so RD_BURST starts with valid data.
    assign w_rd_addr = {r_line, (w_rd_hs ? w_beat_inc : r_beat)};
    assign w_wr_addr = {r_line, r_beat};

    // State register.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_acc) begin
                    w_state_next = req_write_i ? S_WR_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_lat_done) begin
                    w_state_next = S_RD_BURST;
                end
            end
            S_RD_BURST: begin
                if (w_rd_hs && w_rd_last) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WR_BURST: begin
                if (w_wr_hs && w_wr_last) begin
                    w_state_next = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Latch line address on acceptance; step latency and beat counters per state.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_line <= '0;
            r_beat <= 3'd0;
            r_cnt  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_acc) begin
                        r_line <= req_addr_i[ADDR_W-1:6];
                        r_beat <= req_write_i ? 3'd0 : w_start_beat;
                        r_cnt  <= 4'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_lat_done ? 4'd0 : r_cnt + 4'd1;
                end
                S_RD_BURST: begin
                    if (w_rd_hs) begin
                        r_beat <= w_beat_inc;
                        r_cnt  <= w_rd_last ? 4'd0 : r_cnt + 4'd1;
                    end
                end
                S_WR_BURST: begin
                    if (w_wr_hs) begin
                        r_beat <= w_beat_inc;
                    end
                end
                default: begin
                    r_beat <= 3'd0;
                    r_cnt  <= 4'd0;
                end
            endcase
        end
    end

    // Write port: a beat landing in the same cycle as reset is dropped.
    // Contents are never cleared.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_sys_i && w_wr_hs) begin
            r_mem[w_wr_addr] <= wdata_i;
        end
    end

    // Registered read port, free-running.
    // The address is stable while stalled, so the data holds too.
    always_ff @(posedge clk_sys_i) begin
        r_rdata <= r_mem[w_rd_addr];
    end

    assign req_ready_o   = (r_state == S_IDLE);
    assign wdata_ready_o = (r_state == S_WR_BURST);
    assign wr_done_o     = (r_state == S_WR_ACK);
    assign rdata_valid_o = (r_state == S_RD_BURST);
    assign rdata_last_o  = (r_state == S_RD_BURST) && w_rd_last;
    assign rdata_o       = (r_state == S_RD_BURST) ? r_rdata : 64'd0;

endmodule
